lookup2_stream: RTL and testbench

Streaming, parametrised Bob Jenkins lookup2 hash engine for keys of arbitrary length up to 2^LEN_W−1 bytes. Keys arrive as 96-bit (12-byte) beats over a valid/ready handshake. Each beat is absorbed into the a/b/c state and mixed by three mix rounds, one round per cycle. The final length fold and tail masking follow the software reference exactly. Sits in front of the hash-table lookup path and replaces the fixed 12-byte hasher.

---
 rtl/lookup2_pkg.sv | 28 ++
 rtl/lookup2_round.sv | 36 +++
 rtl/lookup2_stream.sv | 190 +++++++++++++++++++
 tb/tb_lookup2_stream.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lookup2_pkg.sv
// lookup2_pkg: shared constants, FSM state type and round shift amounts for
// the streaming lookup2 hash engine.
// Contents: GOLDEN seed, BLOCK_BYTES, round shift constants, state_t.
package lookup2_pkg;

   localparam logic [31:0] GOLDEN      = 32'h9e37_79b9;
   localparam int          BLOCK_BYTES = 12;

   // Shift amounts (s1, s2, s3) for mix rounds 1..3
   localparam logic [4:0] R1_S1 = 5'd13;
   localparam logic [4:0] R1_S2 = 5'd8;
   localparam logic [4:0] R1_S3 = 5'd13;
   localparam logic [4:0] R2_S1 = 5'd12;
   localparam logic [4:0] R2_S2 = 5'd16;
   localparam logic [4:0] R2_S3 = 5'd5;
   localparam logic [4:0] R3_S1 = 5'd3;
   localparam logic [4:0] R3_S2 = 5'd10;
   localparam logic [4:0] R3_S3 = 5'd15;

   typedef enum logic [2:0] {
      S_ACC = 3'd0,
      S_R2  = 3'd1,
      S_R3  = 3'd2,
      S_PAD = 3'd3,
      S_OUT = 3'd4
   } state_t;

endpackage

// File: rtl/lookup2_round.sv
// lookup2_round: one of the three lookup2 mix rounds, selected by round_idx.
// Latency: combinational. Backpressure: none (pure function).
// Ports: a/b/c current state, round_idx (0..2 = round 1..3), a_new/b_new/c_new.
module lookup2_round
   import lookup2_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [31:0] c,
   input  logic [1:0]  round_idx,
   output logic [31:0] a_new,
   output logic [31:0] b_new,
   output logic [31:0] c_new
);

   logic [4:0] s1;
   logic [4:0] s2;
   logic [4:0] s3;

   always_comb begin
      s1 = R3_S1;
      s2 = R3_S2;
      s3 = R3_S3;
      case (round_idx)
         2'd0: begin s1 = R1_S1; s2 = R1_S2; s3 = R1_S3; end
         2'd1: begin s1 = R2_S1; s2 = R2_S2; s3 = R2_S3; end
         default: ;
      endcase
   end

   // Each step consumes the value produced by the step before it.
   assign a_new = (a - b - c) ^ (c >> s1);
   assign b_new = (b - c - a_new) ^ (a_new << s2);
   assign c_new = (c - a_new - b_new) ^ (b_new >> s3);

endmodule

// File: rtl/lookup2_stream.sv
// lookup2_stream: streaming Bob Jenkins lookup2 hash over 12-byte beats.
// Latency: 3 cycles per beat; last beat to result 3 (tail<12), 6 (tail==12), 1 (length error).
// Backpressure: in_ready only in S_ACC; result held in S_OUT until out_ready.
// Ports: CLK, RST_N (sync active-low); in_valid/in_ready/in_data/in_last/in_len;
//        out_valid/out_ready/out_hash/out_err.
// Build option: LOOKUP2_BSWAP_EN maps k[0] to in_data[95:88] (string-literal order).
module lookup2_stream
   import lookup2_pkg::*;
#(
   parameter logic [31:0] INITVAL = 32'h0000_0000,
   parameter int          LEN_W   = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [95:0]      in_data,
   input  logic             in_last,
   input  logic [LEN_W-1:0] in_len,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_hash,
   output logic             out_err
);

   localparam logic [LEN_W:0] BLK_N = (LEN_W+1)'(BLOCK_BYTES);

   state_t           state;
   logic [31:0]      a_q, b_q, c_q;
   logic [31:0]      hash_q;
   logic             err_q;
   logic             first_q;
   logic             pad_pend;   // tail was a full block: one more pad+mix pass
   logic             out_pend;   // the mix in flight is the final one
   logic [LEN_W:0]   count;
   logic [LEN_W-1:0] len_q;

   logic [LEN_W:0]   len_ext;
   logic [LEN_W:0]   tail;
   logic             len_err;
   logic             short_tail;
   logic [7:0]       kb [BLOCK_BYTES];
   logic [31:0]      wa, wb, wc;
   logic [31:0]      base_a, base_b, base_c;
   logic [31:0]      ra_in, rb_in, rc_in;
   logic [31:0]      ra, rb, rc;
   logic [1:0]       ridx;

   assign in_ready  = (state == S_ACC);
   assign out_valid = (state == S_OUT);
   assign out_hash  = hash_q;
   assign out_err   = err_q;

   // tail goes "negative" (wraps) when in_len < count; caught by the compare.
   assign len_ext    = {1'b0, in_len};
   assign tail       = len_ext - count;
   assign len_err    = (len_ext < count) || (tail > BLK_N);
   assign short_tail = in_last && (tail < BLK_N);

   always_comb begin
      for (int i = 0; i < BLOCK_BYTES; i++) begin
`ifdef LOOKUP2_BSWAP_EN
         kb[i] = in_data[95-8*i -: 8];
`else
         kb[i] = in_data[8*i +: 8];
`endif
         if (short_tail && (tail <= (LEN_W+1)'(i)))
            kb[i] = 8'h00;
      end
   end

   assign wa = {kb[3], kb[2], kb[1], kb[0]};
   assign wb = {kb[7], kb[6], kb[5], kb[4]};
   // A partial final block leaves the low byte of c for the key length.
   assign wc = short_tail ? ({kb[10], kb[9], kb[8], 8'h00} + 32'(in_len))
                          : {kb[11], kb[10], kb[9], kb[8]};

   assign base_a = first_q ? GOLDEN  : a_q;
   assign base_b = first_q ? GOLDEN  : b_q;
   assign base_c = first_q ? INITVAL : c_q;

   always_comb begin
      ra_in = a_q;
      rb_in = b_q;
      rc_in = c_q;
      ridx  = 2'd0;
      case (state)
         S_ACC: begin
            ra_in = base_a + wa;
            rb_in = base_b + wb;
            rc_in = base_c + wc;
         end
         S_R2:  ridx = 2'd1;
         S_R3:  ridx = 2'd2;
         S_PAD: rc_in = c_q + 32'(len_q);
         default: ;
      endcase
   end

   lookup2_round u_round (
      .a         (ra_in),
      .b         (rb_in),
      .c         (rc_in),
      .round_idx (ridx),
      .a_new     (ra),
      .b_new     (rb),
      .c_new     (rc)
   );

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state    <= S_ACC;
         a_q      <= '0;
         b_q      <= '0;
         c_q      <= '0;
         hash_q   <= '0;
         err_q    <= 1'b0;
         first_q  <= 1'b1;
         pad_pend <= 1'b0;
         out_pend <= 1'b0;
         count    <= '0;
         len_q    <= '0;
      end else begin
         case (state)
            S_ACC: begin
               if (in_valid) begin
                  first_q <= 1'b0;
                  if (!in_last) begin
                     a_q   <= ra;
                     b_q   <= rb;
                     c_q   <= rc;
                     count <= count + BLK_N;
                     state <= S_R2;
                  end else if (len_err) begin
                     hash_q <= '0;
                     err_q  <= 1'b1;
                     state  <= S_OUT;
                  end else begin
                     a_q      <= ra;
                     b_q      <= rb;
                     c_q      <= rc;
                     len_q    <= in_len;
                     pad_pend <= !short_tail;
                     out_pend <= short_tail;
                     state    <= S_R2;
                  end
               end
            end
            S_R2: begin
               a_q   <= ra;
               b_q   <= rb;
               c_q   <= rc;
               state <= S_R3;
            end
            S_R3: begin
               a_q <= ra;
               b_q <= rb;
               c_q <= rc;
               if (pad_pend) begin
                  state <= S_PAD;
               end else if (out_pend) begin
                  hash_q <= rc;
                  err_q  <= 1'b0;
                  state  <= S_OUT;
               end else begin
                  state <= S_ACC;
               end
            end
            S_PAD: begin
               a_q      <= ra;
               b_q      <= rb;
               c_q      <= rc;
               pad_pend <= 1'b0;
               out_pend <= 1'b1;
               state    <= S_R2;
            end
            S_OUT: begin
               if (out_ready) begin
                  first_q  <= 1'b1;
                  count    <= '0;
                  out_pend <= 1'b0;
                  state    <= S_ACC;
               end
            end
            default: state <= S_ACC;
         endcase
      end
   end

endmodule

// File: tb/tb_lookup2_stream.sv
// tb_lookup2_stream: self-checking bench for lookup2_stream against a
// software-style lookup2 reference model, using an expectation queue.
// Two DUTs share all inputs: INITVAL=0 and INITVAL=32'h1234_5678.
`timescale 1ns/1ps
module tb_lookup2_stream;

   localparam int          LEN_W = 16;
   localparam logic [31:0] IV1   = 32'h1234_5678;

   typedef logic [7:0] bq_t [$];
   typedef struct {
      logic [31:0] h0;
      logic [31:0] h1;
      logic        err;
      int          lat;
      int          acc;
   } exp_t;

   logic             CLK = 1'b0;
   logic             RST_N = 1'b0;
   logic             in_valid = 1'b0;
   logic [95:0]      in_data = '0;
   logic             in_last = 1'b0;
   logic [LEN_W-1:0] in_len = '0;
   logic             out_ready = 1'b1;

   logic             in_ready, out_valid, out_err;
   logic [31:0]      out_hash;
   logic             in_ready1, out_valid1, out_err1;
   logic [31:0]      out_hash1;

   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t sb [$];

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   lookup2_stream #(.INITVAL(32'h0), .LEN_W(LEN_W)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_len(in_len),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_hash(out_hash), .out_err(out_err)
   );

   lookup2_stream #(.INITVAL(IV1), .LEN_W(LEN_W)) dut_iv (
      .CLK(CLK), .RST_N(RST_N),
      .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
      .in_last(in_last), .in_len(in_len),
      .out_valid(out_valid1), .out_ready(out_ready),
      .out_hash(out_hash1), .out_err(out_err1)
   );

   // ---------------- reference model ----------------
   function automatic logic [95:0] ref_mix(input logic [31:0] ai, bi, ci);
      logic [31:0] a, b, c;
      a = ai; b = bi; c = ci;
      a = a - b; a = a - c; a = a ^ (c >> 13);
      b = b - c; b = b - a; b = b ^ (a << 8);
      c = c - a; c = c - b; c = c ^ (b >> 13);
      a = a - b; a = a - c; a = a ^ (c >> 12);
      b = b - c; b = b - a; b = b ^ (a << 16);
      c = c - a; c = c - b; c = c ^ (b >> 5);
      a = a - b; a = a - c; a = a ^ (c >> 3);
      b = b - c; b = b - a; b = b ^ (a << 10);
      c = c - a; c = c - b; c = c ^ (b >> 15);
      return {a, b, c};
   endfunction

   function automatic logic [31:0] ref_hash(input bq_t k, input int length, input logic [31:0] initval);
      logic [31:0] a, b, c;
      int len, p;
      a = 32'h9e37_79b9; b = a; c = initval;
      len = length; p = 0;
      while (len >= 12) begin
         a = a + {k[p+3], k[p+2], k[p+1], k[p]};
         b = b + {k[p+7], k[p+6], k[p+5], k[p+4]};
         c = c + {k[p+11], k[p+10], k[p+9], k[p+8]};
         {a, b, c} = ref_mix(a, b, c);
         p += 12; len -= 12;
      end
      c = c + 32'(length);
      if (len >= 11) c = c + {k[p+10], 24'h0};
      if (len >= 10) c = c + {8'h0, k[p+9], 16'h0};
      if (len >= 9)  c = c + {16'h0, k[p+8], 8'h0};
      if (len >= 8)  b = b + {k[p+7], 24'h0};
      if (len >= 7)  b = b + {8'h0, k[p+6], 16'h0};
      if (len >= 6)  b = b + {16'h0, k[p+5], 8'h0};
      if (len >= 5)  b = b + {24'h0, k[p+4]};
      if (len >= 4)  a = a + {k[p+3], 24'h0};
      if (len >= 3)  a = a + {8'h0, k[p+2], 16'h0};
      if (len >= 2)  a = a + {16'h0, k[p+1], 8'h0};
      if (len >= 1)  a = a + {24'h0, k[p]};
      {a, b, c} = ref_mix(a, b, c);
      return c;
   endfunction

   function automatic bq_t str_bytes(input string s);
      bq_t q;
      for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
      return q;
   endfunction

   function automatic logic [95:0] pack_beat(input bq_t k, input int base, input logic [7:0] fill);
      logic [95:0] d;
      logic [7:0]  bt;
      d = '0;
      for (int i = 0; i < 12; i++) begin
         bt = (base + i < k.size()) ? k[base+i] : fill;
`ifdef LOOKUP2_BSWAP_EN
         d[95-8*i -: 8] = bt;
`else
         d[8*i +: 8] = bt;
`endif
      end
      return d;
   endfunction

   // ---------------- stimulus / checking tasks ----------------
   // Called at a negedge; returns at the negedge after the last beat's acceptance.
   task automatic send_key(input bq_t k, input int nbeats, input int len, input logic [7:0] fill);
      exp_t e;
      int   tail, prev, budget;
      tail  = len - 12 * (nbeats - 1);
      e.err = (tail > 12) || (tail < 0);
      e.h0  = e.err ? 32'h0 : ref_hash(k, len, 32'h0);
      e.h1  = e.err ? 32'h0 : ref_hash(k, len, IV1);
      e.lat = e.err ? 1 : ((tail == 12) ? 6 : 3);
      prev  = 0;
      for (int j = 0; j < nbeats; j++) begin
         in_valid = 1'b1;
         in_data  = pack_beat(k, 12 * j, fill);
         in_last  = (j == nbeats - 1);
         in_len   = (j == nbeats - 1) ? LEN_W'(len) : 16'hBEEF;
         budget   = 0;
         while (in_ready !== 1'b1 && budget < 20) begin
            @(negedge CLK);
            budget++;
         end
         if (budget >= 20) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: beat %0d in_ready=%b required 1", j, in_ready);
         end
         @(posedge CLK);
         @(negedge CLK);
         if (j > 0) begin
            checks++;
            if (cyc - prev !== 3) begin
               errors++;
               $display("FAIL beat_spacing: got %0d cycles required 3", cyc - prev);
            end
         end
         prev = cyc;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = {96{1'b1}};
      e.acc    = prev;
      sb.push_back(e);
   endtask

   task automatic wait_result(input int hold);
      exp_t e;
      int   budget, lat;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("FAIL scoreboard_empty: got 0 entries required 1");
         return;
      end
      e = sb.pop_front();
      out_ready = (hold == 0);
      budget = 0;
      while (out_valid !== 1'b1 && budget < 50) begin
         @(negedge CLK);
         budget++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
         out_ready = 1'b1;
         return;
      end
      lat = cyc - e.acc + 1;
      checks++;
      if (lat != e.lat) begin errors++; $display("FAIL latency: got %0d required %0d", lat, e.lat); end
      checks++;
      if (out_hash !== e.h0) begin errors++; $display("FAIL hash: got %h required %h", out_hash, e.h0); end
      checks++;
      if (out_hash1 !== e.h1) begin errors++; $display("FAIL hash_initval: got %h required %h", out_hash1, e.h1); end
      checks++;
      if (out_err !== e.err) begin errors++; $display("FAIL err: got %b required %b", out_err, e.err); end
      for (int i = 0; i < hold; i++) begin
         @(negedge CLK);
         checks++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_hash !== e.h0 || out_err !== e.err) begin
            errors++;
            $display("FAIL hold_stable: cyc %0d valid=%b ready=%b hash=%h err=%b required 1 0 %h %b",
                     i, out_valid, in_ready, out_hash, out_err, e.h0, e.err);
         end
      end
      out_ready = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("FAIL release: valid=%b ready=%b required 0 1", out_valid, in_ready);
      end
   endtask

   task automatic check_reset_values(input string tag);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_hash !== 32'h0 || out_err !== 1'b0) begin
         errors++;
         $display("FAIL %s: ready=%b valid=%b hash=%h err=%b required 1 0 00000000 0",
                  tag, in_ready, out_valid, out_hash, out_err);
      end
   endtask

   task automatic test_reset();
      RST_N = 1'b0;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      check_reset_values("reset_state");
      RST_N = 1'b1;
      @(negedge CLK);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 3; i++) begin
         send_key(str_bytes("abcdefghijkl"), 1, 12, 8'h00);
         wait_result(0);
      end
   endtask

   task automatic test_short_key();
      send_key(str_bytes("abc"), 1, 3, 8'h00);
      wait_result(0);
      send_key(str_bytes("abc"), 1, 3, 8'hFF);
      wait_result(0);
      send_key(str_bytes("hello world"), 1, 11, 8'hA5);
      wait_result(0);
   endtask

   task automatic test_multi_beat();
      send_key(str_bytes("The quick brown fox jumps"), 3, 25, 8'h5A);
      wait_result(0);
      send_key(str_bytes("abcdefghijklmnopqrstuvwx"), 2, 24, 8'h00);
      wait_result(0);
      send_key(str_bytes("abcdefghijklmnopqrstuvwx"), 3, 24, 8'hFF);
      wait_result(0);
   endtask

   task automatic test_zero_len();
      bq_t empty;
      send_key(empty, 1, 0, 8'($urandom_range(0, 255)));
      wait_result(0);
   endtask

   task automatic test_len_error();
      send_key(str_bytes("abcdefghijklmnopqrstuvwx"), 2, 30, 8'h00);
      wait_result(0);
      send_key(str_bytes("abcdefghijkl"), 1, 13, 8'h00);
      wait_result(0);
      send_key(str_bytes("abcdefghijklmnopqrstuvwx"), 2, 5, 8'h00);
      wait_result(0);
      send_key(str_bytes("after error"), 1, 11, 8'h00);
      wait_result(0);
   endtask

   task automatic test_hold();
      send_key(str_bytes("hold me"), 1, 7, 8'h00);
      wait_result(10);
   endtask

   task automatic test_reset_mid();
      int budget;
      // abort mid-key, after a non-last beat
      in_valid = 1'b1;
      in_data  = pack_beat(str_bytes("0123456789AB"), 0, 8'h00);
      in_last  = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      in_valid = 1'b0;
      RST_N = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check_reset_values("reset_mid_key");
      RST_N = 1'b1;
      send_key(str_bytes("abc"), 1, 3, 8'h00);
      wait_result(0);
      // abort while a result is held
      out_ready = 1'b0;
      send_key(str_bytes("xyz"), 1, 3, 8'h00);
      void'(sb.pop_front());
      budget = 0;
      while (out_valid !== 1'b1 && budget < 20) begin
         @(negedge CLK);
         budget++;
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL held_valid: out_valid=%b required 1", out_valid);
      end
      RST_N = 1'b0;
      @(posedge CLK);
      @(negedge CLK);
      check_reset_values("reset_mid_output");
      RST_N = 1'b1;
      out_ready = 1'b1;
      @(negedge CLK);
      check_reset_values("after_discard");
      send_key(str_bytes("abcdefghijklm"), 2, 13, 8'h00);
      wait_result(0);
   endtask

   initial begin
      test_reset();
      test_back_to_back();
      test_short_key();
      test_multi_beat();
      test_zero_len();
      test_len_error();
      test_hold();
      test_reset_mid();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
